e1_tx_bd_sched: RTL and testbench
=================================

E1_TX_BD_SCHED -- requirements
Module: e1_tx_bd_sched

Interface
REQ-001 SHALL have parameter MFW, default 7, multiframe index width.
REQ-002 SHALL have parameter MAX_AHEAD, default 4, maximum BDs in flight (1..4).
REQ-003 SHALL have ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ctrl_ena  in  1  level; 1 = scheduler runs.
- ctrl_base  in  MFW  first multiframe of the ring.
- ctrl_len_m1  in  MFW  ring length minus one.
- ctrl_ahead  in  3  BDs to keep in flight; 0 and values >MAX_AHEAD mean MAX_AHEAD.
- ctrl_crc_e  in  2  E-bits placed in each submitted BD.
- bd_wr_data  out  MFW+2  {crc_e, mf} to the TX-in BD FIFO.
- bd_wr_ena  out  1  FIFO push strobe.
- bd_wr_full  in  1  FIFO full.
- bd_done  in  1  one-cycle strobe: TX consumed a BD.
- bd_done_mf  in  MFW  mf of the consumed BD.
- bd_miss  in  1  one-cycle strobe: TX underflow.
- stat_busy  out  1  state is not IDLE.
- stat_inflight  out  3  BDs submitted and not yet done.
- stat_rd_ofs  out  MFW  ring offset of the next expected completion.
- stat_err  out  1  sticky sequence error.
- stat_clr  in  1  clears stat_err and miss_cnt.
- miss_cnt  out  8  underflow count.
- evt_done  out  1  pulse per accepted completion.
- evt_wrap  out  1  pulse when completion offset wraps to 0.

Function
REQ-004 SHALL implement states IDLE, RUN, DRAIN.
REQ-005 IDLE: on ctrl_ena=1, latch base, len_m1, ahead and crc_e; clear wr_ofs, rd_ofs and inflight; go to RUN the next cycle.
REQ-006 RUN: assert bd_wr_ena for one cycle when inflight < ahead and bd_wr_full=0; bd_wr_data = {crc_e, (base+wr_ofs) mod 2^MFW}, registered with the strobe.
REQ-007 Issue at most one push per cycle; decide issue from registered state, so a push never coincides with a full FIFO seen in the previous cycle.
REQ-008 wr_ofs and rd_ofs SHALL increment on push / completion and wrap from len_m1 to 0; len_m1=0 gives a ring of one mf.
REQ-009 RUN with ctrl_ena=0 SHALL go to DRAIN; DRAIN issues no pushes and goes to IDLE when inflight=0, or immediately if already 0.
REQ-010 bd_done with inflight>0: decrement inflight, advance rd_ofs, pulse evt_done; if rd_ofs advances to 0, also pulse evt_wrap.
REQ-011 Push and bd_done in the same cycle SHALL leave inflight unchanged.
REQ-012 bd_done with bd_done_mf != base+rd_ofs SHALL set stat_err; the completion is still accepted.
REQ-013 bd_done with inflight=0, or in IDLE, SHALL set stat_err and change nothing else.
REQ-014 miss_cnt SHALL increment on bd_miss, saturate at 255, and clear on stat_clr; when both occur, clear wins.
REQ-015 Outputs evt_* and bd_wr_ena SHALL have one-cycle registered latency from their cause.
REQ-016 ctrl_* changes outside IDLE SHALL be ignored until the next IDLE->RUN transition.

Reset
REQ-017 On rst: state IDLE; bd_wr_ena=0; bd_wr_data=0; inflight, wr_ofs and rd_ofs=0; stat_err=0; miss_cnt=0; evt_*=0.
REQ-018 rst asserted mid-operation SHALL abandon in-flight accounting with no push or event in the cycle after deassertion.

Configuration
REQ-019 Macro E1_TX_BD_SCHED_MISS_CNT_EN:
- Defined: miss counter per REQ-014.
- Undefined: miss_cnt tied to 0, counter logic removed, port kept.

Structure
REQ-020 State encoding and default MFW SHALL live in the shared package e1_pkg.
REQ-021 Ring offset wrap counters SHALL use one sub-module, e1_ring_ptr (width MFW, inputs inc, clr and len_m1), instantiated twice.

Verification
REQ-022 Run: base=10, len_m1=3, ahead=2, no done -> pushes mf 10, 11, then stop; inflight=2.
REQ-023 Completions 10, 11, 12, 13 returned in order -> pushes 12, 13, 10 (wrap); evt_wrap on the 4th done; stat_err=0.
REQ-024 bd_done_mf=99 while 10 is expected -> stat_err=1, inflight decremented; stat_clr -> stat_err=0.
REQ-025 bd_wr_full held high 20 cycles in RUN -> no bd_wr_ena; first push the cycle after full drops.
REQ-026 ctrl_ena=0 with inflight=2 -> DRAIN, no pushes; after 2 dones -> IDLE, stat_busy=0.
REQ-027 300 bd_miss strobes -> miss_cnt=255 (macro defined), or 0 (macro undefined); base=126 with MFW=7 -> mf sequence 126, 127, 0.

Source files
------------

// File: rtl/e1_pkg.sv
// Shared types and defaults for the E1 transmit buffer-descriptor path.
package e1_pkg;

    localparam int E1_MFW = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } e1_state_t;

endpackage

// File: rtl/e1_ring_ptr.sv
// Ring offset counter: counts 0..len_m1 then wraps; clr has priority over inc.
module e1_ring_ptr
    import e1_pkg::*;
#(
    parameter int MFW = E1_MFW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           inc,
    input  logic [MFW-1:0] len_m1,
    output logic [MFW-1:0] ofs,
    output logic           last
);

    assign last = (ofs == len_m1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ofs <= '0;
        end else if (clr) begin
            ofs <= '0;
        end else if (inc) begin
            ofs <= last ? '0 : ofs + 1'b1;
        end
    end

endmodule

// File: rtl/e1_tx_bd_sched.sv
// E1 TX BD scheduler: keeps up to 'ahead' multiframe BDs queued to the TX FIFO and tracks completions.
// Optional underflow counter enabled by defining E1_TX_BD_SCHED_MISS_CNT_EN.
module e1_tx_bd_sched
    import e1_pkg::*;
#(
    parameter int MFW       = E1_MFW,
    parameter int MAX_AHEAD = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ctrl_ena,
    input  logic [MFW-1:0] ctrl_base,
    input  logic [MFW-1:0] ctrl_len_m1,
    input  logic [2:0]     ctrl_ahead,
    input  logic [1:0]     ctrl_crc_e,
    output logic [MFW+1:0] bd_wr_data,
    output logic           bd_wr_ena,
    input  logic           bd_wr_full,
    input  logic           bd_done,
    input  logic [MFW-1:0] bd_done_mf,
    input  logic           bd_miss,
    output logic           stat_busy,
    output logic [2:0]     stat_inflight,
    output logic [MFW-1:0] stat_rd_ofs,
    output logic           stat_err,
    input  logic           stat_clr,
    output logic [7:0]     miss_cnt,
    output logic           evt_done,
    output logic           evt_wrap
);

    e1_state_t      state_q, state_d;
    logic [MFW-1:0] base_q, len_q;
    logic [2:0]     ahead_q, ahead_norm;
    logic [1:0]     crc_q;
    logic [2:0]     inflight_q;
    logic [MFW-1:0] wr_ofs, rd_ofs;
    logic           wr_last, rd_last;
    logic           issue, accept, start, ptr_clr;

    assign ahead_norm = (ctrl_ahead == 3'd0 || int'(ctrl_ahead) > MAX_AHEAD)
                        ? 3'(MAX_AHEAD) : ctrl_ahead;

    // Issue looks only at registered occupancy and this cycle's full flag;
    // the strobe itself appears one cycle later.
    assign issue   = (state_q == ST_RUN) && (inflight_q < ahead_q) && !bd_wr_full;
    assign accept  = bd_done && (state_q != ST_IDLE) && (inflight_q != 3'd0);
    assign start   = (state_q == ST_IDLE) && ctrl_ena;
    assign ptr_clr = (state_q == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ctrl_ena) state_d = ST_RUN;
            ST_RUN:   if (!ctrl_ena) state_d = ST_DRAIN;
            ST_DRAIN: if (inflight_q == 3'd0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    e1_ring_ptr #(.MFW(MFW)) u_wr_ptr (
        .clk    (clk),
        .rst    (rst),
        .clr    (ptr_clr),
        .inc    (issue),
        .len_m1 (len_q),
        .ofs    (wr_ofs),
        .last   (wr_last)
    );

    e1_ring_ptr #(.MFW(MFW)) u_rd_ptr (
        .clk    (clk),
        .rst    (rst),
        .clr    (ptr_clr),
        .inc    (accept),
        .len_m1 (len_q),
        .ofs    (rd_ofs),
        .last   (rd_last)
    );

    logic unused_wr_last;
    assign unused_wr_last = wr_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q     <= '0;
            len_q      <= '0;
            ahead_q    <= '0;
            crc_q      <= '0;
            inflight_q <= '0;
            bd_wr_ena  <= 1'b0;
            bd_wr_data <= '0;
            evt_done   <= 1'b0;
            evt_wrap   <= 1'b0;
        end else begin
            bd_wr_ena <= issue;
            evt_done  <= accept;
            evt_wrap  <= accept && rd_last;
            if (issue) bd_wr_data <= {crc_q, base_q + wr_ofs};
            if (start) begin
                base_q     <= ctrl_base;
                len_q      <= ctrl_len_m1;
                ahead_q    <= ahead_norm;
                crc_q      <= ctrl_crc_e;
                inflight_q <= '0;
            end else if (issue && !accept) begin
                inflight_q <= inflight_q + 3'd1;
            end else if (accept && !issue) begin
                inflight_q <= inflight_q - 3'd1;
            end
        end
    end

    // A new error outranks a simultaneous clear so no event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_err <= 1'b0;
        end else if (bd_done && (!accept || bd_done_mf != base_q + rd_ofs)) begin
            stat_err <= 1'b1;
        end else if (stat_clr) begin
            stat_err <= 1'b0;
        end
    end

`ifdef E1_TX_BD_SCHED_MISS_CNT_EN
    logic [7:0] miss_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_q <= '0;
        end else if (stat_clr) begin
            miss_q <= '0;
        end else if (bd_miss && miss_q != 8'hFF) begin
            miss_q <= miss_q + 8'd1;
        end
    end
    assign miss_cnt = miss_q;
`else
    logic unused_miss;
    assign unused_miss = bd_miss;
    assign miss_cnt    = '0;
`endif

    assign stat_busy     = (state_q != ST_IDLE);
    assign stat_inflight = inflight_q;
    assign stat_rd_ofs   = rd_ofs;

endmodule

// File: tb/tb_e1_tx_bd_sched.sv
// Directed bench for e1_tx_bd_sched (MFW=7, MAX_AHEAD=4).
module tb_e1_tx_bd_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ctrl_ena = 1'b0;
    logic [6:0] ctrl_base = '0;
    logic [6:0] ctrl_len_m1 = '0;
    logic [2:0] ctrl_ahead = '0;
    logic [1:0] ctrl_crc_e = '0;
    logic [8:0] bd_wr_data;
    logic       bd_wr_ena;
    logic       bd_wr_full = 1'b0;
    logic       bd_done = 1'b0;
    logic [6:0] bd_done_mf = '0;
    logic       bd_miss = 1'b0;
    logic       stat_busy;
    logic [2:0] stat_inflight;
    logic [6:0] stat_rd_ofs;
    logic       stat_err;
    logic       stat_clr = 1'b0;
    logic [7:0] miss_cnt;
    logic       evt_done;
    logic       evt_wrap;

    int checks = 0;
    int errors = 0;

    logic [8:0] push_q[$];
    int done_cnt = 0;
    int wrap_cnt = 0;
    int wrap_at  = 0;

    e1_tx_bd_sched #(.MFW(7), .MAX_AHEAD(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .ctrl_ena      (ctrl_ena),
        .ctrl_base     (ctrl_base),
        .ctrl_len_m1   (ctrl_len_m1),
        .ctrl_ahead    (ctrl_ahead),
        .ctrl_crc_e    (ctrl_crc_e),
        .bd_wr_data    (bd_wr_data),
        .bd_wr_ena     (bd_wr_ena),
        .bd_wr_full    (bd_wr_full),
        .bd_done       (bd_done),
        .bd_done_mf    (bd_done_mf),
        .bd_miss       (bd_miss),
        .stat_busy     (stat_busy),
        .stat_inflight (stat_inflight),
        .stat_rd_ofs   (stat_rd_ofs),
        .stat_err      (stat_err),
        .stat_clr      (stat_clr),
        .miss_cnt      (miss_cnt),
        .evt_done      (evt_done),
        .evt_wrap      (evt_wrap)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bd_wr_ena) push_q.push_back(bd_wr_data);
        if (evt_done) done_cnt = done_cnt + 1;
        if (evt_wrap) begin
            wrap_cnt = wrap_cnt + 1;
            wrap_at  = done_cnt;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_done(input logic [6:0] mf);
        bd_done    = 1'b1;
        bd_done_mf = mf;
        tick(1);
        bd_done    = 1'b0;
    endtask

    task automatic test_reset;
        tick(2);
        checks++; if (bd_wr_ena !== 1'b0) begin errors++; $display("FAIL reset_wr_ena got %0b exp 0", bd_wr_ena); end
        checks++; if (bd_wr_data !== 9'd0) begin errors++; $display("FAIL reset_wr_data got %0h exp 0", bd_wr_data); end
        checks++; if (stat_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", stat_busy); end
        checks++; if (stat_inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight got %0d exp 0", stat_inflight); end
        checks++; if (stat_rd_ofs !== 7'd0) begin errors++; $display("FAIL reset_rd_ofs got %0d exp 0", stat_rd_ofs); end
        checks++; if ({stat_err, evt_done, evt_wrap} !== 3'b000) begin errors++; $display("FAIL reset_err_evt got %b exp 000", {stat_err, evt_done, evt_wrap}); end
        checks++; if (miss_cnt !== 8'd0) begin errors++; $display("FAIL reset_miss got %0d exp 0", miss_cnt); end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_run;
        ctrl_base   = 7'd10;
        ctrl_len_m1 = 7'd3;
        ctrl_ahead  = 3'd2;
        ctrl_crc_e  = 2'b01;
        ctrl_ena    = 1'b1;
        push_q.delete();
        tick(10);
        checks++; if (push_q.size() != 2) begin errors++; $display("FAIL run_push_count got %0d exp 2", push_q.size()); end
        else begin
            checks++; if (push_q[0] !== {2'b01, 7'd10}) begin errors++; $display("FAIL run_push0 got %0h exp %0h", push_q[0], {2'b01, 7'd10}); end
            checks++; if (push_q[1] !== {2'b01, 7'd11}) begin errors++; $display("FAIL run_push1 got %0h exp %0h", push_q[1], {2'b01, 7'd11}); end
        end
        checks++; if (stat_inflight !== 3'd2) begin errors++; $display("FAIL run_inflight got %0d exp 2", stat_inflight); end
        checks++; if (stat_busy !== 1'b1) begin errors++; $display("FAIL run_busy got %0b exp 1", stat_busy); end
    endtask

    task automatic test_completions;
        logic [6:0] exp_mf[4];
        exp_mf = '{7'd12, 7'd13, 7'd10, 7'd11};
        push_q.delete();
        done_cnt = 0;
        wrap_cnt = 0;
        wrap_at  = 0;
        send_done(7'd10); tick(2);
        send_done(7'd11); tick(2);
        send_done(7'd12); tick(2);
        send_done(7'd13); tick(4);
        checks++; if (push_q.size() != 4) begin errors++; $display("FAIL cmpl_push_count got %0d exp 4", push_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (push_q[i] !== {2'b01, exp_mf[i]}) begin
                    errors++; $display("FAIL cmpl_push%0d got %0h exp %0h", i, push_q[i], {2'b01, exp_mf[i]});
                end
            end
        end
        checks++; if (done_cnt != 4) begin errors++; $display("FAIL cmpl_evt_done got %0d exp 4", done_cnt); end
        checks++; if (wrap_cnt != 1 || wrap_at != 4) begin errors++; $display("FAIL cmpl_evt_wrap got cnt %0d at %0d exp cnt 1 at 4", wrap_cnt, wrap_at); end
        checks++; if (stat_err !== 1'b0) begin errors++; $display("FAIL cmpl_err got %0b exp 0", stat_err); end
        checks++; if (stat_rd_ofs !== 7'd0) begin errors++; $display("FAIL cmpl_rd_ofs got %0d exp 0", stat_rd_ofs); end
    endtask

    task automatic test_bad_mf;
        send_done(7'd99);
        checks++; if (stat_err !== 1'b1) begin errors++; $display("FAIL badmf_err got %0b exp 1", stat_err); end
        checks++; if (stat_inflight !== 3'd1) begin errors++; $display("FAIL badmf_inflight got %0d exp 1", stat_inflight); end
        checks++; if (evt_done !== 1'b1) begin errors++; $display("FAIL badmf_evt_done got %0b exp 1", evt_done); end
        checks++; if (stat_rd_ofs !== 7'd1) begin errors++; $display("FAIL badmf_rd_ofs got %0d exp 1", stat_rd_ofs); end
        stat_clr = 1'b1;
        tick(1);
        stat_clr = 1'b0;
        checks++; if (stat_err !== 1'b0) begin errors++; $display("FAIL badmf_clr got %0b exp 0", stat_err); end
        tick(3);
    endtask

    task automatic test_full;
        int pushes;
        pushes     = 0;
        bd_wr_full = 1'b1;
        send_done(7'd11);
        for (int i = 0; i < 20; i++) begin
            if (bd_wr_ena) pushes++;
            tick(1);
        end
        checks++; if (pushes != 0) begin errors++; $display("FAIL full_pushes got %0d exp 0", pushes); end
        checks++; if (stat_inflight !== 3'd1) begin errors++; $display("FAIL full_inflight got %0d exp 1", stat_inflight); end
        bd_wr_full = 1'b0;
        checks++; if (bd_wr_ena !== 1'b0) begin errors++; $display("FAIL full_drop_same got %0b exp 0", bd_wr_ena); end
        tick(1);
        checks++; if (bd_wr_ena !== 1'b1) begin errors++; $display("FAIL full_drop_next got %0b exp 1", bd_wr_ena); end
        checks++; if (bd_wr_data !== {2'b01, 7'd13}) begin errors++; $display("FAIL full_data got %0h exp %0h", bd_wr_data, {2'b01, 7'd13}); end
        tick(2);
    endtask

    task automatic test_drain;
        push_q.delete();
        ctrl_ena = 1'b0;
        tick(1);
        checks++; if (stat_busy !== 1'b1 || stat_inflight !== 3'd2) begin errors++; $display("FAIL drain_enter got busy %0b infl %0d exp busy 1 infl 2", stat_busy, stat_inflight); end
        send_done(7'd12); tick(1);
        send_done(7'd13); tick(3);
        checks++; if (stat_busy !== 1'b0) begin errors++; $display("FAIL drain_idle got %0b exp 0", stat_busy); end
        checks++; if (stat_inflight !== 3'd0) begin errors++; $display("FAIL drain_inflight got %0d exp 0", stat_inflight); end
        checks++; if (push_q.size() != 0) begin errors++; $display("FAIL drain_pushes got %0d exp 0", push_q.size()); end
        checks++; if (stat_err !== 1'b0) begin errors++; $display("FAIL drain_err got %0b exp 0", stat_err); end
    endtask

    task automatic test_idle_done;
        send_done(7'd5);
        checks++; if (stat_err !== 1'b1) begin errors++; $display("FAIL idle_done_err got %0b exp 1", stat_err); end
        checks++; if (evt_done !== 1'b0 || stat_inflight !== 3'd0) begin errors++; $display("FAIL idle_done_side got evt %0b infl %0d exp 0 0", evt_done, stat_inflight); end
        stat_clr = 1'b1;
        tick(1);
        stat_clr = 1'b0;
    endtask

    task automatic test_miss;
        logic [7:0] exp_sat;
`ifdef E1_TX_BD_SCHED_MISS_CNT_EN
        exp_sat = 8'd255;
`else
        exp_sat = 8'd0;
`endif
        bd_miss = 1'b1;
        tick(300);
        bd_miss = 1'b0;
        tick(1);
        checks++; if (miss_cnt !== exp_sat) begin errors++; $display("FAIL miss_sat got %0d exp %0d", miss_cnt, exp_sat); end
        bd_miss  = 1'b1;
        stat_clr = 1'b1;
        tick(1);
        bd_miss  = 1'b0;
        stat_clr = 1'b0;
        checks++; if (miss_cnt !== 8'd0) begin errors++; $display("FAIL miss_clr_wins got %0d exp 0", miss_cnt); end
    endtask

    task automatic test_mf_wrap;
        logic [6:0] exp_mf[4];
        exp_mf = '{7'd126, 7'd127, 7'd0, 7'd1};
        ctrl_base   = 7'd126;
        ctrl_len_m1 = 7'd3;
        ctrl_ahead  = 3'd0;
        ctrl_crc_e  = 2'b10;
        ctrl_ena    = 1'b1;
        push_q.delete();
        tick(1);
        ctrl_base = 7'd5;
        tick(8);
        checks++; if (push_q.size() != 4) begin errors++; $display("FAIL mfwrap_count got %0d exp 4", push_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (push_q[i] !== {2'b10, exp_mf[i]}) begin
                    errors++; $display("FAIL mfwrap_push%0d got %0h exp %0h", i, push_q[i], {2'b10, exp_mf[i]});
                end
            end
        end
        checks++; if (stat_inflight !== 3'd4) begin errors++; $display("FAIL mfwrap_inflight got %0d exp 4", stat_inflight); end
    endtask

    task automatic test_reset_mid;
        rst = 1'b1;
        tick(2);
        checks++; if (stat_inflight !== 3'd0 || stat_busy !== 1'b0) begin errors++; $display("FAIL midrst_state got infl %0d busy %0b exp 0 0", stat_inflight, stat_busy); end
        rst = 1'b0;
        tick(1);
        checks++; if ({bd_wr_ena, evt_done, evt_wrap} !== 3'b000) begin errors++; $display("FAIL midrst_quiet got %b exp 000", {bd_wr_ena, evt_done, evt_wrap}); end
        checks++; if (stat_busy !== 1'b1) begin errors++; $display("FAIL midrst_run got %0b exp 1", stat_busy); end
        tick(1);
        checks++; if (bd_wr_ena !== 1'b1 || bd_wr_data !== {2'b10, 7'd5}) begin errors++; $display("FAIL midrst_push got ena %0b data %0h exp 1 %0h", bd_wr_ena, bd_wr_data, {2'b10, 7'd5}); end
    endtask

    initial begin
        test_reset;
        test_run;
        test_completions;
        test_bad_mf;
        test_full;
        test_drain;
        test_idle_done;
        test_miss;
        test_mf_wrap;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
